// File: rtl/bf_ct_post.sv
// Post-reduction stage of the Kyber Cooley-Tukey butterfly: aligns a/tag with the reduced
// product r, forms x=(a+r) mod Q and y=(a-r) mod Q, and buffers results behind a credit gate.
module bf_ct_post #(
    parameter int RED_LAT = 1,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int Q       = 3329
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [11:0]      iss_a,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic [11:0]      red_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_x,
    output logic [11:0]      out_y,
    output logic [TAG_W-1:0] out_tag
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             r_dl_valid [RED_LAT];
    logic [11:0]      r_dl_a     [RED_LAT];
    logic [TAG_W-1:0] r_dl_tag   [RED_LAT];

    logic [11:0]      r_mem_x   [DEPTH];
    logic [11:0]      r_mem_y   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_cnt;

    logic             w_iss_fire;
    logic             w_out_fire;
    logic             w_arr;
    logic [11:0]      w_arr_a;
    logic [11:0]      w_r;
    logic [12:0]      w_sum;
    logic [12:0]      w_dif;
    logic [11:0]      w_x;
    logic [11:0]      w_y;

    assign iss_ready  = (r_cnt < CNT_W'(DEPTH));
    assign out_valid  = (r_occ != '0);
    assign w_iss_fire = iss_valid && iss_ready;
    assign w_out_fire = out_valid && out_ready;

    // Stage 0 captures on issue; later stages simply shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RED_LAT; i++) begin
                r_dl_valid[i] <= 1'b0;
                r_dl_a[i]     <= '0;
                r_dl_tag[i]   <= '0;
            end
        end else begin
            r_dl_valid[0] <= w_iss_fire;
            if (w_iss_fire) begin
                r_dl_a[0]   <= iss_a;
                r_dl_tag[0] <= iss_tag;
            end
            for (int i = 1; i < RED_LAT; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_a[i]     <= r_dl_a[i-1];
                r_dl_tag[i]   <= r_dl_tag[i-1];
            end
        end
    end

    // red_r is only meaningful in the arrival cycle; mask it otherwise so X never leaks in.
    assign w_arr   = r_dl_valid[RED_LAT-1];
    assign w_arr_a = r_dl_a[RED_LAT-1];
    assign w_r     = w_arr ? red_r : 12'd0;
    assign w_sum   = {1'b0, w_arr_a} + {1'b0, w_r};
    assign w_dif   = {1'b0, w_arr_a} - {1'b0, w_r};
    assign w_x     = (w_sum >= 13'(Q)) ? 12'(w_sum - 13'(Q)) : w_sum[11:0];
    assign w_y     = w_dif[12] ? 12'(w_dif + 13'(Q)) : w_dif[11:0];

    always_ff @(posedge clk) begin
        if (w_arr) begin
            r_mem_x[r_wr_ptr]   <= w_x;
            r_mem_y[r_wr_ptr]   <= w_y;
            r_mem_tag[r_wr_ptr] <= r_dl_tag[RED_LAT-1];
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover delay-line entries too, so an arrival always finds a free FIFO slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_arr)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_out_fire)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_arr, w_out_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            case ({w_iss_fire, w_out_fire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_x   = out_valid ? r_mem_x[r_rd_ptr]   : 12'd0;
    assign out_y   = out_valid ? r_mem_y[r_rd_ptr]   : 12'd0;
    assign out_tag = out_valid ? r_mem_tag[r_rd_ptr] : '0;

endmodule

// File: tb/tb_bf_ct_post.sv
// Scoreboard bench for bf_ct_post: driver pushes modular-arithmetic expectations on issue,
// a monitor pops and compares on every output handshake.
module tb_bf_ct_post;
    localparam int Q = 3329;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [11:0] iss_a;
    logic [3:0]  iss_tag;
    logic [11:0] red_r;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_x;
    logic [11:0] out_y;
    logic [3:0]  out_tag;

    bf_ct_post #(.RED_LAT(1), .DEPTH(4), .TAG_W(4), .Q(3329)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_a(iss_a), .iss_tag(iss_tag),
        .red_r(red_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_tag(out_tag)
    );

    typedef struct {
        int x;
        int y;
        int tag;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          pend_v   = 0;
    logic [11:0] pend_r   = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input bit v, input logic [11:0] a, input logic [3:0] tag,
                         input logic [11:0] r, input bit ordy, input bit lat,
                         input bit chk_rdy, output bit acc);
        exp_t e;
        bit n_v;
        red_r     = pend_v ? pend_r : 12'($urandom_range(0, 4095));
        iss_valid = v;
        iss_a     = a;
        iss_tag   = tag;
        out_ready = ordy;
        if (chk_rdy) chk("stream_iss_ready", int'(iss_ready), 1);
        acc = v && iss_ready;
        if (acc) begin
            e.x   = (int'(a) + int'(r)) % Q;
            e.y   = (int'(a) - int'(r) + Q) % Q;
            e.tag = int'(tag);
            e.cyc = lat ? cyc + 2 : -1;
            sb.push_back(e);
            $display("issue a=%0d r=%0d tag=%0d exp_x=%0d exp_y=%0d", a, r, tag, e.x, e.y);
        end
        n_v = acc;
        @(negedge clk);
        pend_v = n_v;
        pend_r = r;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            drive(0, 0, 0, 0, 1, 0, 0, acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_tag=%0d required=none", out_tag);
                end else begin
                    e = sb.pop_front();
                    $display("pop x=%0d y=%0d tag=%0d (exp %0d %0d %0d)", out_x, out_y, out_tag, e.x, e.y, e.tag);
                    chk("out_x", int'(out_x), e.x);
                    chk("out_y", int'(out_y), e.y);
                    chk("out_tag", int'(out_tag), e.tag);
                    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        bit acc;
        int accepted;
        logic [11:0] h_a, h_r;
        logic [3:0]  h_tag;
        int ca[5] = '{0, 3328, 1, 0, 3328};
        int cr[5] = '{0, 1, 1, 3328, 3328};

        rst = 1; iss_valid = 0; iss_a = 0; iss_tag = 0; red_r = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_iss_ready", int'(iss_ready), 1);
        rst = 0;
        @(negedge clk);
        chk("post_rst_iss_ready", int'(iss_ready), 1);

        // Single butterfly
        drive(1, 12'd100, 4'd5, 12'd3300, 1, 1, 0, acc);
        drain();

        // Corner arithmetic
        for (int i = 0; i < 5; i++)
            drive(1, 12'(ca[i]), 4'(i), 12'(cr[i]), 1, 1, 0, acc);
        drain();

        // Backpressure: exactly DEPTH accepted
        accepted = 0;
        h_a = 12'($urandom_range(0, Q-1));
        h_r = 12'($urandom_range(0, Q-1));
        for (int i = 0; i < 8; i++) begin
            drive(1, h_a, 4'(accepted), h_r, 0, 0, 0, acc);
            if (acc) begin
                accepted++;
                h_a = 12'($urandom_range(0, Q-1));
                h_r = 12'($urandom_range(0, Q-1));
            end
        end
        chk("bp_accepted", accepted, 4);
        chk("bp_ready_low", int'(iss_ready), 0);
        drive(0, 0, 0, 0, 1, 0, 0, acc);
        chk("bp_ready_after_pop", int'(iss_ready), 1);
        drain();

        // Streaming
        for (int i = 0; i < 16; i++)
            drive(1, 12'($urandom_range(0, Q-1)), 4'(i), 12'($urandom_range(0, Q-1)), 1, 1, 1, acc);
        drain();

        // Random traffic with random backpressure
        h_a = 12'($urandom_range(0, Q-1));
        h_r = 12'($urandom_range(0, Q-1));
        h_tag = 4'($urandom_range(0, 15));
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), h_a, h_tag, h_r, 1'($urandom_range(0, 1)), 0, 0, acc);
            if (acc) begin
                h_a = 12'($urandom_range(0, Q-1));
                h_r = 12'($urandom_range(0, Q-1));
                h_tag = 4'($urandom_range(0, 15));
            end
        end
        drain();

        // Reset mid-stream
        for (int i = 0; i < 3; i++)
            drive(1, 12'($urandom_range(0, Q-1)), 4'(i + 8), 12'($urandom_range(0, Q-1)), 0, 0, 0, acc);
        #3;
        rst = 1;
        iss_valid = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_x", int'(out_x), 0);
        chk("midrst_out_y", int'(out_y), 0);
        chk("midrst_out_tag", int'(out_tag), 0);
        chk("midrst_iss_ready", int'(iss_ready), 1);
        sb.delete();
        pend_v = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++)
            drive(0, 0, 0, 0, 1, 0, 0, acc);
        chk("after_rst_idle", int'(out_valid), 0);
        drive(1, 12'd2000, 4'd9, 12'd1500, 1, 1, 0, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf_ct_post.md
Name: bf_ct_post

Overview:
- Post-reduction stage of the Kyber Cooley-Tukey butterfly (q = 3329).
- Sits directly downstream of the Barrett/bit-modular reduction of the twiddle product b*zeta. Consumes the 12-bit reduced product r, together with the butterfly's a operand captured at issue time.
- Produces x = (a + r) mod q and y = (a - r) mod q with a valid/ready output.
- Delay-aligns a and a tag to the reduction latency and applies credit-based backpressure at issue, because the reduction pipe has no stall.

Parameters:
- RED_LAT, 1, cycles from issue (product presented to reduction) to red_r valid; the PIPE1 reduction gives 1.
- DEPTH, 4, output buffer entries; must be >= RED_LAT+1.
- TAG_W, 4, width of the sideband tag (coefficient index).
- Q, 3329, modulus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iss_valid  in  1  butterfly issued this cycle; its product enters the reduction now.
- iss_ready  out  1  issue permitted.
- iss_a  in  12  butterfly a operand, 0..Q-1.
- iss_tag  in  TAG_W  sideband tag.
- red_r  in  12  reduced product from the reduction stage, 0..Q-1.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts.
- out_x  out  12  (a+r) mod Q.
- out_y  out  12  (a-r) mod Q.
- out_tag  out  TAG_W  tag of head entry.

Behaviour:
- Handshakes:
  - Issue handshake: iss_valid && iss_ready.
  - Output handshake: out_valid && out_ready.
  - iss_valid while iss_ready=0 is ignored; there is no capture, and the upstream must hold the operands.
- Delay line: RED_LAT-stage shift register of {valid, a, tag}. Stage 0 loads on the issue handshake; otherwise valid=0.
- Arrival: the delay-line output valid marks the cycle in which red_r belongs to that entry. red_r is sampled only in that cycle.
- Arithmetic, combinational at arrival:
  - s = a + r, 13-bit. x = s - Q if s >= Q, else s[11:0].
  - d = a - r, 13-bit two's complement. y = d + Q if d < 0, else d[11:0].
  - Results are truncated to 12 bits. For in-range inputs, outputs are 0..Q-1.
- Output buffer: circular FIFO of DEPTH entries {x, y, tag}, written on arrival.
  - Head drives out_x/out_y/out_tag. out_valid = (occupancy != 0).
  - Pop on the output handshake.
  - Write and pop in the same cycle is legal, including the cases occupancy=0 and occupancy=DEPTH-1.
  - Pointers wrap modulo DEPTH.
- Credits:
  - cnt = in-flight delay-line entries + FIFO occupancy, width clog2(DEPTH+1).
  - iss_ready = (cnt < DEPTH), combinational from cnt.
  - cnt updates: +1 on issue handshake, -1 on output handshake. Simultaneous issue and pop leaves cnt unchanged.
  - This guarantees an arrival never finds the FIFO full, so there is no overflow path.
  - cnt is never allowed to exceed DEPTH.
- Latency and throughput:
  - Issue at edge t gives out_valid at edge t+RED_LAT+1 when the FIFO is empty.
  - With out_ready held at 1: one result per cycle, no bubbles, iss_ready stays 1 (cnt <= RED_LAT+1 <= DEPTH).
- Ordering: strict FIFO; outputs leave in issue order.
- Reset (asynchronous, immediate):
  - All delay-line valids 0, FIFO pointers and occupancy 0, cnt 0.
  - out_valid=0; out_x, out_y, out_tag = 0. iss_ready=1 during and after reset.
- Reset mid-operation: all in-flight and buffered entries are discarded. No entry issued before reset may appear after release.
- Pulses: no X-propagation from red_r when no arrival is pending; FIFO data is written only on arrival.

Test Plan:
- Reset: assert rst asynchronously between edges -> out_valid=0 and out_x/out_y/out_tag=0 immediately; iss_ready=1; cnt=0 after release.
- Single butterfly: issue a=100, tag=5 at edge t, with red_r=3300 at t+1 -> at t+2: out_valid=1, out_x=71, out_y=129, out_tag=5.
- Corner arithmetic, one per issue:
  - a=0, r=0 -> x=0, y=0.
  - a=3328, r=1 -> x=0, y=3327.
  - a=1, r=1 -> x=2, y=0.
  - a=0, r=3328 -> x=3328, y=1.
  - a=3328, r=3328 -> x=3327, y=0.
- Backpressure: out_ready=0, iss_valid=1 continuously, tags 0,1,2,... -> exactly 4 issues accepted, then iss_ready=0. Raise out_ready -> tags 0..3 emerge in order, and iss_ready returns 1 in the cycle after the first pop.
- Streaming: out_ready=1, 16 back-to-back issues with random a/r -> 16 consecutive out_valid cycles starting at issue+2, results matching the reference model, iss_ready never 0.
- Reset mid-stream: 3 entries in flight or buffered, pulse rst -> out_valid drops at once. After release, no output appears until a new issue, whose result arrives with correct values 2 cycles later.
